// File: rtl/dmem_responder.sv
// dmem_responder: responder end of the CPU data-memory interface.
// Accepts one request at a time, waits WAIT_CYCLES, accesses a word RAM with
// byte enables, and holds the response until the requester takes it.
module dmem_responder #(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_we,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int         AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  generate
    if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
      $error("dmem_responder: WAIT_CYCLES must lie in 0..15");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("dmem_responder: DEPTH must be a power of two >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state, state_nxt;
  logic [3:0]      wait_cnt, wait_cnt_nxt;
  logic            do_access;

  logic [31:0]     lat_addr, lat_wdata;
  logic            lat_we;
  logic [3:0]      lat_be;

  logic [31:0]     acc_addr, acc_wdata;
  logic            acc_we;
  logic [3:0]      acc_be;
  logic            acc_err;
  logic [AW-1:0]   acc_idx;

  logic [31:0]     mem [DEPTH];

  // With zero wait states the access happens on the acceptance edge itself,
  // so the request is taken straight from the inputs; otherwise from the latch.
  assign acc_addr  = (state == IDLE) ? req_addr  : lat_addr;
  assign acc_we    = (state == IDLE) ? req_we    : lat_we;
  assign acc_be    = (state == IDLE) ? req_be    : lat_be;
  assign acc_wdata = (state == IDLE) ? req_wdata : lat_wdata;
  assign acc_err   = (acc_addr[1:0] != 2'b00) || (acc_addr[31:2] >= 30'(DEPTH));
  assign acc_idx   = acc_addr[AW+1:2];

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

  // Next-state logic: count down wait states and flag the access edge.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    do_access    = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (WAIT_CYCLES == 0) begin
            state_nxt = RESP;
            do_access = 1'b1;
          end else begin
            state_nxt    = WAIT;
            wait_cnt_nxt = WAIT_LOAD;
          end
        end
      end
      WAIT: begin
        if (wait_cnt == 4'd0) begin
          state_nxt = RESP;
          do_access = 1'b1;
        end else begin
          wait_cnt_nxt = wait_cnt - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, request latch and response registers; response is only updated on the access edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      wait_cnt  <= 4'd0;
      lat_addr  <= 32'd0;
      lat_we    <= 1'b0;
      lat_be    <= 4'd0;
      lat_wdata <= 32'd0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (state == IDLE && req_valid) begin
        lat_addr  <= req_addr;
        lat_we    <= req_we;
        lat_be    <= req_be;
        lat_wdata <= req_wdata;
      end
      if (do_access) begin
        rsp_err   <= acc_err;
        rsp_rdata <= (acc_err || acc_we) ? 32'd0 : mem[acc_idx];
      end
    end
  end

  // RAM write port: enabled byte lanes only, never on a faulting access or during reset.
  always_ff @(posedge clk) begin
    if (!rst && do_access && acc_we && !acc_err) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_be[i]) mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: table-driven bench with a response scoreboard, covering
// three responder configurations (2, 4 and 0 wait states).
module tb_dmem_responder;

  typedef struct {
    int          d;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          hold;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        req_valid [3];
  logic        req_ready [3];
  logic [31:0] req_addr  [3];
  logic        req_we    [3];
  logic [3:0]  req_be    [3];
  logic [31:0] req_wdata [3];
  logic        rsp_valid [3];
  logic        rsp_ready [3];
  logic [31:0] rsp_rdata [3];
  logic        rsp_err   [3];
  logic        busy      [3];

  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_lat [3] = '{3, 5, 1};
  exp_t sb [$];
  vec_t tbl [$];

  dmem_responder #(.DEPTH(64), .WAIT_CYCLES(2)) dut_w2 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_addr(req_addr[0]),
    .req_we(req_we[0]), .req_be(req_be[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_err(rsp_err[0]), .busy(busy[0])
  );

  dmem_responder #(.DEPTH(64), .WAIT_CYCLES(4)) dut_w4 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_addr(req_addr[1]),
    .req_we(req_we[1]), .req_be(req_be[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_err(rsp_err[1]), .busy(busy[1])
  );

  dmem_responder #(.DEPTH(64), .WAIT_CYCLES(0)) dut_w0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[2]), .req_ready(req_ready[2]), .req_addr(req_addr[2]),
    .req_we(req_we[2]), .req_be(req_be[2]), .req_wdata(req_wdata[2]),
    .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]), .rsp_rdata(rsp_rdata[2]),
    .rsp_err(rsp_err[2]), .busy(busy[2])
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Last-resort guard against a hung run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic checkBit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  // Drive one request, measure latency, compare against the scoreboard and
  // optionally hold off the response for v.hold cycles before taking it.
  task automatic applyStimulus(input vec_t v);
    int   d;
    int   lat;
    exp_t e;
    d = v.d;
    sb.push_back('{v.exp_rdata, v.exp_err});

    @(negedge clk);
    lat = 0;
    while (req_ready[d] !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checkBit($sformatf("dut%0d req_ready before request", d), req_ready[d], 1'b1);

    req_valid[d] = 1'b1;
    req_addr[d]  = v.addr;
    req_we[d]    = v.we;
    req_be[d]    = v.be;
    req_wdata[d] = v.wdata;
    @(posedge clk);
    #1;
    req_valid[d] = 1'b0;
    req_addr[d]  = $urandom();
    req_wdata[d] = $urandom();
    req_be[d]    = 4'($urandom_range(0, 15));

    @(negedge clk);
    checkBit($sformatf("dut%0d busy after accept", d), busy[d], 1'b1);
    lat = 1;
    while (rsp_valid[d] !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checkOutput($sformatf("dut%0d latency addr %h", d, v.addr), 32'(lat), 32'(exp_lat[d]));

    e = sb.pop_front();
    if (rsp_valid[d] === 1'b1) begin
      checkOutput($sformatf("dut%0d rdata addr %h", d, v.addr), rsp_rdata[d], e.rdata);
      checkBit($sformatf("dut%0d err addr %h", d, v.addr), rsp_err[d], e.err);

      for (int h = 0; h < v.hold; h++) begin
        req_valid[d] = 1'b1;
        req_we[d]    = 1'b1;
        req_addr[d]  = 32'h10;
        req_be[d]    = 4'hF;
        req_wdata[d] = 32'h0;
        @(negedge clk);
        checkBit("hold rsp_valid", rsp_valid[d], 1'b1);
        checkOutput("hold rsp_rdata", rsp_rdata[d], e.rdata);
        checkBit("hold rsp_err", rsp_err[d], e.err);
        checkBit("hold req_ready", req_ready[d], 1'b0);
      end
      req_valid[d] = 1'b0;

      rsp_ready[d] = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready[d] = 1'b0;
      checkBit($sformatf("dut%0d idle after handshake", d), req_ready[d], 1'b1);
      checkBit($sformatf("dut%0d rsp_valid drop", d), rsp_valid[d], 1'b0);
      checkOutput($sformatf("dut%0d rdata retained", d), rsp_rdata[d], e.rdata);
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_valid[i] = 1'b0;
      req_addr[i]  = 32'h0;
      req_we[i]    = 1'b0;
      req_be[i]    = 4'h0;
      req_wdata[i] = 32'h0;
      rsp_ready[i] = 1'b0;
    end

    //        d  addr           we    be     wdata          exp_rdata      err   hold
    tbl.push_back('{0, 32'h0000_0010, 1'b1, 4'hF, 32'hDEADBEEF, 32'h0000_0000, 1'b0, 0});
    tbl.push_back('{0, 32'h0000_0010, 1'b0, 4'h0, 32'h0000_0000, 32'hDEADBEEF, 1'b0, 0});
    tbl.push_back('{0, 32'h0000_0020, 1'b1, 4'hF, 32'h11223344, 32'h0000_0000, 1'b0, 0});
    tbl.push_back('{0, 32'h0000_0020, 1'b1, 4'h5, 32'hAABBCCDD, 32'h0000_0000, 1'b0, 0});
    tbl.push_back('{0, 32'h0000_0020, 1'b0, 4'h0, 32'h0000_0000, 32'h11BB33DD, 1'b0, 0});
    tbl.push_back('{0, 32'h0000_0020, 1'b1, 4'h0, 32'hFFFFFFFF, 32'h0000_0000, 1'b0, 0});
    tbl.push_back('{0, 32'h0000_0020, 1'b0, 4'h0, 32'h0000_0000, 32'h11BB33DD, 1'b0, 0});
    tbl.push_back('{0, 32'h0000_0002, 1'b0, 4'h0, 32'h0000_0000, 32'h0000_0000, 1'b1, 0});
    tbl.push_back('{0, 32'h0000_0000, 1'b1, 4'hF, 32'hCAFEF00D, 32'h0000_0000, 1'b0, 0});
    tbl.push_back('{0, 32'h0000_0100, 1'b1, 4'hF, 32'h12345678, 32'h0000_0000, 1'b1, 0});
    tbl.push_back('{0, 32'h0000_0000, 1'b0, 4'h0, 32'h0000_0000, 32'hCAFEF00D, 1'b0, 0});
    tbl.push_back('{0, 32'h0000_0012, 1'b1, 4'hF, 32'h0000_0000, 32'h0000_0000, 1'b1, 0});
    tbl.push_back('{0, 32'h0000_0010, 1'b0, 4'h0, 32'h0000_0000, 32'hDEADBEEF, 1'b0, 5});
    tbl.push_back('{0, 32'h0000_0010, 1'b0, 4'h0, 32'h0000_0000, 32'hDEADBEEF, 1'b0, 0});
    tbl.push_back('{0, 32'h0000_00FC, 1'b1, 4'hF, 32'h0BADC0DE, 32'h0000_0000, 1'b0, 0});
    tbl.push_back('{0, 32'h0000_00FC, 1'b0, 4'h0, 32'h0000_0000, 32'h0BADC0DE, 1'b0, 0});
    tbl.push_back('{0, 32'h8000_0010, 1'b0, 4'h0, 32'h0000_0000, 32'h0000_0000, 1'b1, 0});
    tbl.push_back('{0, 32'h0000_00FF, 1'b0, 4'h0, 32'h0000_0000, 32'h0000_0000, 1'b1, 0});
    tbl.push_back('{0, 32'h0000_0020, 1'b1, 4'hA, 32'h99887766, 32'h0000_0000, 1'b0, 0});
    tbl.push_back('{0, 32'h0000_0020, 1'b0, 4'h0, 32'h0000_0000, 32'h99BB77DD, 1'b0, 0});
    tbl.push_back('{1, 32'h0000_0030, 1'b1, 4'hF, 32'h5555AAAA, 32'h0000_0000, 1'b0, 0});
    tbl.push_back('{1, 32'h0000_0030, 1'b0, 4'h0, 32'h0000_0000, 32'h5555AAAA, 1'b0, 0});
    tbl.push_back('{2, 32'h0000_0030, 1'b1, 4'hF, 32'hA5A5A5A5, 32'h0000_0000, 1'b0, 0});
    tbl.push_back('{2, 32'h0000_0030, 1'b0, 4'h0, 32'h0000_0000, 32'hA5A5A5A5, 1'b0, 0});
    tbl.push_back('{2, 32'h0000_0104, 1'b0, 4'h0, 32'h0000_0000, 32'h0000_0000, 1'b1, 0});
    tbl.push_back('{2, 32'h0000_0030, 1'b1, 4'h8, 32'h3C000000, 32'h0000_0000, 1'b0, 0});
    tbl.push_back('{2, 32'h0000_0030, 1'b0, 4'h0, 32'h0000_0000, 32'h3CA5A5A5, 1'b0, 0});

    // Reset, then hold idle for ten cycles.
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("dut%0d reset rsp_rdata", i), rsp_rdata[i], 32'h0);
      checkBit($sformatf("dut%0d reset rsp_err", i), rsp_err[i], 1'b0);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        checkBit($sformatf("dut%0d idle req_ready", i), req_ready[i], 1'b1);
        checkBit($sformatf("dut%0d idle rsp_valid", i), rsp_valid[i], 1'b0);
        checkBit($sformatf("dut%0d idle busy", i), busy[i], 1'b0);
      end
    end

    for (int k = 0; k < tbl.size(); k++) applyStimulus(tbl[k]);

    // Reset two cycles into a four-wait-state store: the store must be dropped.
    @(negedge clk);
    req_valid[1] = 1'b1;
    req_addr[1]  = 32'h30;
    req_we[1]    = 1'b1;
    req_be[1]    = 4'hF;
    req_wdata[1] = 32'h12345678;
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    checkBit("midwait busy", busy[1], 1'b1);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkBit("midwait reset req_ready", req_ready[1], 1'b1);
    checkBit("midwait reset busy", busy[1], 1'b0);
    checkBit("midwait reset rsp_valid", rsp_valid[1], 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checkBit("midwait no response", rsp_valid[1], 1'b0);
    end
    applyStimulus('{1, 32'h30, 1'b0, 4'h0, 32'h0, 32'h5555AAAA, 1'b0, 0});
    applyStimulus('{2, 32'h30, 1'b0, 4'h0, 32'h0, 32'h3CA5A5A5, 1'b0, 0});

    checkOutput("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
